// File: rtl/mlp_seq_pkg.sv
// Shared types and constants for the MLP layer sequencer and its address generator.
package mlp_seq_pkg;

    typedef enum logic [3:0] {
        VALU_NOP  = 4'd0,
        VALU_FMA  = 4'd1,
        VALU_RELU = 4'd2
    } valu_func_e;

    typedef logic [3:0] state_e;

    localparam state_e S_IDLE      = 4'd0;
    localparam state_e S_BIAS_RD   = 4'd1;
    localparam state_e S_BIAS_CAP  = 4'd2;
    localparam state_e S_FETCH     = 4'd3;
    localparam state_e S_ISSUE     = 4'd4;
    localparam state_e S_WAIT      = 4'd5;
    localparam state_e S_ACT_ISSUE = 4'd6;
    localparam state_e S_ACT_WAIT  = 4'd7;
    localparam state_e S_WRITE     = 4'd8;
    localparam state_e S_DONE      = 4'd9;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mlp_seq_addr_gen.sv
// Pair/input counters and scratchpad address generation for one layer job.
module mlp_seq_addr_gen
    import mlp_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              k_step,
    input  logic              p_step,
    input  logic [DIM_W-1:0]  in_dim,
    input  logic [DIM_W-1:0]  out_dim,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic [DIM_W-1:0]  pair_idx,
    output logic              last_k,
    output logic              last_pair,
    output logic [1:0]        lane_mask,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] b_addr
);

    logic [DIM_W-1:0]   p_cnt;
    logic [DIM_W-1:0]   k_cnt;
    logic [2*DIM_W-1:0] row_offset;

    // NOTE: counter state uses non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            p_cnt <= '0;
            k_cnt <= '0;
        end else begin
            if (k_step) k_cnt <= last_k ? '0 : k_cnt + DIM_W'(1);
            if (p_step) p_cnt <= p_cnt + DIM_W'(1);
        end
    end

    assign last_k    = ({1'b0, k_cnt} + (DIM_W+1)'(1)) == {1'b0, in_dim};
    // Last pair once rows 2p and 2p+1 reach or pass N.
    assign last_pair = ({1'b0, p_cnt, 1'b0} + (DIM_W+2)'(2)) >= {2'b00, out_dim};
    assign lane_mask = (last_pair && out_dim[0]) ? 2'b01 : 2'b11;
    assign pair_idx  = p_cnt;

    // Full-width product, then silently truncated to the scratchpad address space.
    assign row_offset = {{DIM_W{1'b0}}, p_cnt} * {{DIM_W{1'b0}}, in_dim};
    assign w_addr     = w_base + ADDR_W'(row_offset) + ADDR_W'(k_cnt);
    assign x_addr     = x_base + ADDR_W'(k_cnt);
    assign b_addr     = b_base + ADDR_W'(p_cnt);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one dense layer y = act(W*x + b) two output rows at a time on the 2-lane FP32 valu.
module mlp_layer_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIM_W-1:0]  cfg_in_dim,
    input  logic [DIM_W-1:0]  cfg_out_dim,
    input  logic              cfg_relu,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [63:0]       w_rd_data,
    output logic              x_rd_en,
    output logic [ADDR_W-1:0] x_rd_addr,
    input  logic [31:0]       x_rd_data,
    output logic              valu_valid,
    output valu_func_e        valu_func,
    output logic [31:0]       valu_a_0,
    output logic [31:0]       valu_a_1,
    output logic [31:0]       valu_b_0,
    output logic [31:0]       valu_b_1,
    output logic [31:0]       valu_c_0,
    output logic [31:0]       valu_c_1,
    input  logic              valu_out_valid,
    input  logic [31:0]       valu_out_0,
    input  logic [31:0]       valu_out_1,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [63:0]       y_data,
    output logic [1:0]        y_mask,
    output logic [DIM_W-1:0]  y_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state, state_next;
    logic [DIM_W-1:0]  in_dim, out_dim;
    logic              relu_en;
    logic [ADDR_W-1:0] w_base, x_base, b_base;
    logic [31:0]       acc_0, acc_1;
    logic              err_q;

    logic              accept, cfg_bad, start, k_step, p_step;
    logic [DIM_W-1:0]  pair_idx;
    logic              last_k, last_pair;
    logic [1:0]        lane_mask;
    logic [ADDR_W-1:0] w_addr, x_addr, b_addr;

    assign accept  = cfg_valid && (state == S_IDLE);
    assign cfg_bad = (cfg_in_dim == '0) || (cfg_out_dim == '0);
    assign start   = accept && !cfg_bad;
    assign k_step  = (state == S_WAIT) && valu_out_valid;
    assign p_step  = (state == S_WRITE) && y_ready && !last_pair;

    mlp_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .k_step    (k_step),
        .p_step    (p_step),
        .in_dim    (in_dim),
        .out_dim   (out_dim),
        .w_base    (w_base),
        .x_base    (x_base),
        .b_base    (b_base),
        .pair_idx  (pair_idx),
        .last_k    (last_k),
        .last_pair (last_pair),
        .lane_mask (lane_mask),
        .w_addr    (w_addr),
        .x_addr    (x_addr),
        .b_addr    (b_addr)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = S_BIAS_RD;
            S_BIAS_RD:   state_next = S_BIAS_CAP;
            S_BIAS_CAP:  state_next = S_FETCH;
            S_FETCH:     state_next = S_ISSUE;
            S_ISSUE:     state_next = S_WAIT;
            S_WAIT: begin
                if (valu_out_valid) begin
                    if (!last_k)      state_next = S_FETCH;
                    else if (relu_en) state_next = S_ACT_ISSUE;
                    else              state_next = S_WRITE;
                end
            end
            S_ACT_ISSUE: state_next = S_ACT_WAIT;
            S_ACT_WAIT:  if (valu_out_valid) state_next = S_WRITE;
            S_WRITE:     if (y_ready) state_next = last_pair ? S_DONE : S_BIAS_RD;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= accept && cfg_bad;
        end
    end

    // NOTE: config and accumulators carry no reset; every output that shows them is gated by state.
    always_ff @(posedge clock) begin
        if (start) begin
            in_dim  <= cfg_in_dim;
            out_dim <= cfg_out_dim;
            relu_en <= cfg_relu;
            w_base  <= cfg_w_base;
            x_base  <= cfg_x_base;
            b_base  <= cfg_b_base;
        end
        case (state)
            S_BIAS_CAP: begin
                acc_0 <= w_rd_data[31:0];
                acc_1 <= w_rd_data[63:32];
            end
            S_WAIT, S_ACT_WAIT: begin
                if (valu_out_valid) begin
                    acc_0 <= valu_out_0;
                    acc_1 <= valu_out_1;
                end
            end
            default: ;
        endcase
    end

    // Memory ports: only BIAS_RD and FETCH touch the scratchpads.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        x_rd_en   = 1'b0;
        x_rd_addr = '0;
        if (state == S_BIAS_RD) begin
            w_rd_en   = 1'b1;
            w_rd_addr = b_addr;
        end else if (state == S_FETCH) begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_addr;
            x_rd_en   = 1'b1;
            x_rd_addr = x_addr;
        end
    end

    // Operand muxing: FMA takes weights/activation straight from the read ports.
    always_comb begin
        valu_valid = 1'b0;
        valu_func  = VALU_NOP;
        valu_a_0   = FP32_ZERO;
        valu_a_1   = FP32_ZERO;
        valu_b_0   = FP32_ZERO;
        valu_b_1   = FP32_ZERO;
        valu_c_0   = FP32_ZERO;
        valu_c_1   = FP32_ZERO;
        if (state == S_ISSUE) begin
            valu_valid = 1'b1;
            valu_func  = VALU_FMA;
            valu_a_0   = w_rd_data[31:0];
            valu_a_1   = w_rd_data[63:32];
            valu_b_0   = x_rd_data;
            valu_b_1   = x_rd_data;
            valu_c_0   = acc_0;
            valu_c_1   = acc_1;
        end else if (state == S_ACT_ISSUE) begin
            valu_valid = 1'b1;
            valu_func  = VALU_RELU;
            valu_a_0   = acc_0;
            valu_a_1   = acc_1;
        end
    end

    assign y_valid   = (state == S_WRITE);
    assign y_data    = y_valid ? {acc_1, acc_0} : 64'h0;
    assign y_mask    = y_valid ? lane_mask : 2'b00;
    assign y_index   = y_valid ? pair_idx : '0;
    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench: scratchpad and valu models plus a scoreboard of expected y beats.
module tb_mlp_layer_sequencer;

    localparam int VALU_LAT = 3;
    localparam int STALL    = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_in_dim, cfg_out_dim;
    logic        cfg_relu;
    logic [15:0] cfg_w_base, cfg_x_base, cfg_b_base;
    logic        w_rd_en, x_rd_en;
    logic [15:0] w_rd_addr, x_rd_addr;
    logic [63:0] w_rd_data;
    logic [31:0] x_rd_data;
    logic        valu_valid;
    logic [3:0]  valu_func;
    logic [31:0] valu_a_0, valu_a_1, valu_b_0, valu_b_1, valu_c_0, valu_c_1;
    logic        valu_out_valid;
    logic [31:0] valu_out_0, valu_out_1;
    logic        y_valid, y_ready;
    logic [63:0] y_data;
    logic [1:0]  y_mask;
    logic [15:0] y_index;
    logic        busy, done, err;

    always #5 clock = ~clock;

    mlp_layer_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_in_dim     (cfg_in_dim),
        .cfg_out_dim    (cfg_out_dim),
        .cfg_relu       (cfg_relu),
        .cfg_w_base     (cfg_w_base),
        .cfg_x_base     (cfg_x_base),
        .cfg_b_base     (cfg_b_base),
        .w_rd_en        (w_rd_en),
        .w_rd_addr      (w_rd_addr),
        .w_rd_data      (w_rd_data),
        .x_rd_en        (x_rd_en),
        .x_rd_addr      (x_rd_addr),
        .x_rd_data      (x_rd_data),
        .valu_valid     (valu_valid),
        .valu_func      (valu_func),
        .valu_a_0       (valu_a_0),
        .valu_a_1       (valu_a_1),
        .valu_b_0       (valu_b_0),
        .valu_b_1       (valu_b_1),
        .valu_c_0       (valu_c_0),
        .valu_c_1       (valu_c_1),
        .valu_out_valid (valu_out_valid),
        .valu_out_0     (valu_out_0),
        .valu_out_1     (valu_out_1),
        .y_valid        (y_valid),
        .y_ready        (y_ready),
        .y_data         (y_data),
        .y_mask         (y_mask),
        .y_index        (y_index),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FP32 <-> real helpers; all test values are exactly representable.
    function automatic real f2r(input logic [31:0] f);
        real v;
        int  e;
        if (f[30:0] == 31'h0) return 0.0;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real         v;
        int          e;
        logic        s;
        logic [22:0] m;
        logic [7:0]  eb;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        v = s ? -r : r;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m  = 23'($rtoi((v - 1.0) * 8388608.0));
        eb = 8'(e);
        return {s, eb, m};
    endfunction

    function automatic logic [31:0] valu_op(input logic [3:0] f, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
        if (f == 4'd1) return r2f(f2r(a) * f2r(b) + f2r(c));
        if (f == 4'd2) return a[31] ? 32'h0 : a;
        return 32'h0;
    endfunction

    // Scratchpads with one cycle read latency.
    logic [63:0] w_mem [256];
    logic [31:0] x_mem [256];

    always @(posedge clock) begin
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr[7:0]];
        if (x_rd_en) x_rd_data <= x_mem[x_rd_addr[7:0]];
    end

    // valu model: result strobe appears VALU_LAT cycles after the issue cycle.
    logic        valu_pend = 1'b0;
    int          valu_cnt  = 0;
    logic [31:0] res_0, res_1;

    always @(negedge clock) begin
        valu_out_valid = 1'b0;
        if (valu_pend) begin
            valu_cnt--;
            if (valu_cnt == 0) begin
                valu_out_valid = 1'b1;
                valu_out_0     = res_0;
                valu_out_1     = res_1;
                valu_pend      = 1'b0;
            end
        end
        if (valu_valid) begin
            valu_pend = 1'b1;
            valu_cnt  = VALU_LAT;
            res_0     = valu_op(valu_func, valu_a_0, valu_b_0, valu_c_0);
            res_1     = valu_op(valu_func, valu_a_1, valu_b_1, valu_c_1);
        end
    end

    // Activity monitor.
    int          fma_cnt = 0, relu_cnt = 0, rd_cnt = 0, done_cnt = 0;
    logic        vv_prev = 1'b0;
    logic [15:0] bias_addrs [$];

    always @(negedge clock) begin
        if (!reset) begin
            if (valu_valid) begin
                check("valu_single_cycle", 64'(vv_prev), 64'd0);
                if (valu_func == 4'd1) fma_cnt++;
                if (valu_func == 4'd2) relu_cnt++;
            end
            if (w_rd_en) rd_cnt++;
            if (x_rd_en) rd_cnt++;
            if (w_rd_en && !x_rd_en) bias_addrs.push_back(w_rd_addr);
            if (done) done_cnt++;
        end
        vv_prev = valu_valid;
    end

    // Output sink and scoreboard.
    typedef struct {
        logic [63:0] data;
        logic [1:0]  mask;
        logic [15:0] index;
    } beat_t;

    beat_t       sb [$];
    int          stall_left = 0;
    int          beats = 0;
    logic [63:0] held_y, last_y;

    always @(negedge clock) begin
        beat_t e;
        if (y_valid && stall_left > 0) begin
            y_ready = 1'b0;
            if (stall_left == STALL) held_y = y_data;
            else check("stall_y_stable", y_data, held_y);
            check("stall_no_reads", 64'({w_rd_en, x_rd_en}), 64'd0);
            stall_left--;
        end else begin
            y_ready = 1'b1;
            if (y_valid) begin
                beats++;
                last_y = y_data;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    if (e.mask == 2'b01) check("y_lane0", 64'(y_data[31:0]), 64'(e.data[31:0]));
                    else                 check("y_data", y_data, e.data);
                    check("y_mask", 64'(y_mask), 64'(e.mask));
                    check("y_index", 64'(y_index), 64'(e.index));
                end
            end
        end
    end

    // Job data: rows of W, x and bias as reals.
    real wm [4][4];
    real xv [4];
    real bv [4];

    function automatic logic [31:0] ref_row(input int r, input int k_dim, input bit relu);
        real acc;
        acc = bv[r];
        for (int k = 0; k < k_dim; k++) acc = wm[r][k] * xv[k] + acc;
        if (relu && acc < 0.0) acc = 0.0;
        return r2f(acc);
    endfunction

    task automatic setup_job(input int k_dim, input int n_dim, input bit relu,
                             input int wb, input int xb, input int bb);
        beat_t e;
        for (int p = 0; p < (n_dim + 1) / 2; p++) begin
            w_mem[bb + p] = {r2f(bv[2*p+1]), r2f(bv[2*p])};
            for (int k = 0; k < k_dim; k++)
                w_mem[wb + p*k_dim + k] = {r2f(wm[2*p+1][k]), r2f(wm[2*p][k])};
            e.data  = {ref_row(2*p+1, k_dim, relu), ref_row(2*p, k_dim, relu)};
            e.mask  = (2*p + 1 == n_dim) ? 2'b01 : 2'b11;
            e.index = 16'(p);
            sb.push_back(e);
        end
        for (int k = 0; k < k_dim; k++) x_mem[xb + k] = r2f(xv[k]);
    endtask

    task automatic start_job(input int k_dim, input int n_dim, input bit relu,
                             input int wb, input int xb, input int bb);
        @(negedge clock);
        cfg_in_dim  = 16'(k_dim);
        cfg_out_dim = 16'(n_dim);
        cfg_relu    = relu;
        cfg_w_base  = 16'(wb);
        cfg_x_base  = 16'(xb);
        cfg_b_base  = 16'(bb);
        cfg_valid   = 1'b1;
        @(negedge clock);
        cfg_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 1;
        while (!done && cycles < 2000) begin
            @(negedge clock);
            cycles++;
        end
        if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic load_basic();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) wm[r][k] = 0.0;
            bv[r] = 0.0;
            xv[r] = 0.0;
        end
        wm[0][0] = 1.0; wm[0][1] = 2.0;
        wm[1][0] = 3.0; wm[1][1] = 4.0;
        xv[0] = 1.0;    xv[1] = 1.0;
        bv[0] = 0.5;    bv[1] = -10.0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, f0, r0, rd0, n, d0;
        for (int i = 0; i < 256; i++) begin
            w_mem[i] = 64'h0;
            x_mem[i] = 32'h0;
        end
        w_rd_data = 64'h0;
        x_rd_data = 32'h0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_in_dim = '0; cfg_out_dim = '0; cfg_relu = 1'b0;
        cfg_w_base = '0; cfg_x_base = '0; cfg_b_base = '0;
        y_ready = 1'b1;
        valu_out_valid = 1'b0;
        valu_out_0 = '0;
        valu_out_1 = '0;
        repeat (3) @(negedge clock);
        check("rst_ctrl", 64'({cfg_ready, busy, w_rd_en, x_rd_en, valu_valid, y_valid, done, err}),
              64'b1000_0000);
        check("rst_func", 64'(valu_func), 64'd0);
        check("rst_ydata", y_data, 64'd0);
        check("rst_ops", {valu_a_0, valu_c_1}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic 2x2 job, no activation, exact latency.
        load_basic();
        setup_job(2, 2, 1'b0, 16, 64, 128);
        start_job(2, 2, 1'b0, 16, 64, 128);
        wait_done("t1", cyc);
        check("t1_latency", 64'(cyc), 64'd14);
        check("t1_ydata", last_y, 64'hC0400000_40600000);
        check("t1_sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clock);
        check("t1_back_idle", 64'({done, busy, cfg_ready}), 64'b001);

        // Same job with ReLU: two FMA issues and one RELU issue.
        f0 = fma_cnt;
        r0 = relu_cnt;
        setup_job(2, 2, 1'b1, 16, 64, 128);
        start_job(2, 2, 1'b1, 16, 64, 128);
        wait_done("t2", cyc);
        check("t2_ydata", last_y, 64'h00000000_40600000);
        check("t2_fma_issues", 64'(fma_cnt - f0), 64'd2);
        check("t2_relu_issues", 64'(relu_cnt - r0), 64'd1);
        check("t2_sb_drained", 64'(sb.size()), 64'd0);

        // Odd N with K=3 and a 20-cycle output stall on the first beat.
        load_basic();
        wm[0][2] = 0.25; wm[1][2] = -1.0;
        wm[2][0] = -1.0; wm[2][1] = 0.5; wm[2][2] = 1.0;
        xv[2] = 2.0;
        bv[2] = 2.0;
        bias_addrs.delete();
        n = beats;
        setup_job(3, 3, 1'b0, 20, 70, 200);
        stall_left = STALL;
        start_job(3, 3, 1'b0, 20, 70, 200);
        wait_done("t3", cyc);
        check("t3_beats", 64'(beats - n), 64'd2);
        check("t3_bias_reads", 64'(bias_addrs.size()), 64'd2);
        if (bias_addrs.size() == 2) begin
            check("t3_bias_addr0", 64'(bias_addrs[0]), 64'd200);
            check("t3_bias_addr1", 64'(bias_addrs[1]), 64'd201);
        end
        check("t3_sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clock);

        // Zero-size jobs: error pulse, no activity.
        rd0 = rd_cnt;
        f0  = fma_cnt + relu_cnt;
        start_job(0, 2, 1'b0, 16, 64, 128);
        check("k0_err_pulse", 64'({err, cfg_ready, busy}), 64'b110);
        @(negedge clock);
        check("k0_err_cleared", 64'(err), 64'd0);
        repeat (4) @(negedge clock);
        check("k0_no_reads", 64'(rd_cnt - rd0), 64'd0);
        check("k0_no_valu", 64'(fma_cnt + relu_cnt - f0), 64'd0);
        check("k0_ready", 64'(cfg_ready), 64'd1);
        start_job(2, 0, 1'b0, 16, 64, 128);
        check("n0_err_pulse", 64'({err, busy}), 64'b10);
        repeat (3) @(negedge clock);
        check("n0_no_reads", 64'(rd_cnt - rd0), 64'd0);

        // Reset while waiting on the valu, then a clean job.
        load_basic();
        setup_job(2, 2, 1'b0, 16, 64, 128);
        start_job(2, 2, 1'b0, 16, 64, 128);
        n = 0;
        while (!valu_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t5_issue_seen", 64'(valu_valid), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5_reset_idle", 64'({busy, y_valid, valu_valid, done, err, cfg_ready}), 64'b000001);
        sb.delete();
        d0 = done_cnt;
        repeat (8) @(negedge clock);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_still_idle", 64'({busy, cfg_ready}), 64'b01);

        setup_job(2, 2, 1'b0, 40, 90, 150);
        start_job(2, 2, 1'b0, 40, 90, 150);
        wait_done("t6", cyc);
        check("t6_latency", 64'(cyc), 64'd14);
        check("t6_ydata", last_y, 64'hC0400000_40600000);
        check("t6_sb_drained", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
